sed_piso_tx: RTL and testbench

- Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready load handshake, then shifts it out one bit per enabled clock on a single serial line.
- Serial output holds its value between shift enables, like a latch output that only follows when enabled.
- Serves as the sending end for the serial bit stream consumed by the team's latch/flip-flop capture stages.

---
 rtl/sed_piso_tx.sv | 128 ++++++++++++
 tb/tb_sed_piso_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sed_piso_tx.sv
// sed_piso_tx: parallel-in/serial-out transmitter.
// Accepts a WIDTH-bit word over a valid/ready load handshake, then shifts it
// out one bit per clock edge with shift_en=1. The serial output holds its
// value between shift enables and keeps the last bit after a word completes.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   d          parallel word to transmit
//   load_valid d is valid for loading
//   load_ready block can accept a word (idle)
//   shift_en   bit-rate tick; one bit shifted per enabled edge
//   clr        synchronous abort, priority over load and shift
//   q          serial data; holds between shifts
//   q_valid    one-cycle strobe: q took a new bit this cycle
//   busy       word in progress
//   done       one-cycle pulse with the q_valid of the last bit
module sed_piso_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  input  logic             clr,
  output logic             q,
  output logic             q_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_q;
  logic             w_q_nxt;
  logic             r_q_valid;
  logic             w_q_valid_nxt;
  logic             r_done;
  logic             w_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_q       <= 1'b0;
      r_q_valid <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_cnt     <= w_cnt_nxt;
      r_q       <= w_q_nxt;
      r_q_valid <= w_q_valid_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_cnt_nxt     = r_cnt;
    w_q_nxt       = r_q;
    w_q_valid_nxt = 1'b0;
    w_done_nxt    = 1'b0;

    if (clr) begin
      w_state_nxt = S_IDLE;
      w_shreg_nxt = '0;
      w_cnt_nxt   = '0;
      w_q_nxt     = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (load_valid) begin
            w_shreg_nxt = d;
            w_cnt_nxt   = '0;
            w_state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (shift_en) begin
            // The register always moves toward the output end, so the next
            // bit to send is always at the same position.
            if (MSB_FIRST != 0) begin
              w_q_nxt     = r_shreg[WIDTH-1];
              w_shreg_nxt = r_shreg << 1;
            end else begin
              w_q_nxt     = r_shreg[0];
              w_shreg_nxt = r_shreg >> 1;
            end
            w_q_valid_nxt = 1'b1;
            if (r_cnt == LAST) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt   = r_cnt + CW'(1);
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign load_ready = (r_state == S_IDLE);
  assign busy       = (r_state == S_SHIFT);
  assign q          = r_q;
  assign q_valid    = r_q_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_sed_piso_tx.sv
// tb_sed_piso_tx: directed bench for sed_piso_tx (WIDTH=8), with one
// MSB-first and one LSB-first instance driven by the same stimulus.
module tb_sed_piso_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d;
  logic       load_valid;
  logic       shift_en;
  logic       clr;

  logic q0, qv0, done0, busy0, lr0;
  logic q1, qv1, done1, busy1, lr1;

  always #5 clk = ~clk;

  sed_piso_tx #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .d(d), .load_valid(load_valid),
    .load_ready(lr0), .shift_en(shift_en), .clr(clr),
    .q(q0), .q_valid(qv0), .busy(busy0), .done(done0)
  );

  sed_piso_tx #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .d(d), .load_valid(load_valid),
    .load_ready(lr1), .shift_en(shift_en), .clr(clr),
    .q(q1), .q_valid(qv1), .busy(busy1), .done(done1)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level reference: remembers the accepted word and how many bits of
  // it have been sent, and picks the outgoing bit by index.
  logic [7:0] m_word  = '0;
  int         m_sent  = 0;
  logic       m_busy  = 1'b0;
  logic       m_q0    = 1'b0;
  logic       m_q1    = 1'b0;
  logic       m_qv    = 1'b0;
  logic       m_done  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_word = '0; m_sent = 0; m_busy = 1'b0;
      m_q0 = 1'b0; m_q1 = 1'b0; m_qv = 1'b0; m_done = 1'b0;
    end else begin
      m_qv   = 1'b0;
      m_done = 1'b0;
      if (clr) begin
        m_busy = 1'b0; m_sent = 0; m_word = '0;
        m_q0 = 1'b0; m_q1 = 1'b0;
      end else if (!m_busy) begin
        if (load_valid) begin
          m_word = d; m_sent = 0; m_busy = 1'b1;
        end
      end else if (shift_en) begin
        m_q0 = m_word[7 - m_sent];
        m_q1 = m_word[m_sent];
        m_sent++;
        m_qv = 1'b1;
        if (m_sent == 8) begin
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic cap0[$];
  logic cap1[$];
  int   st0[$];

  // Per-cycle compare against the model plus strobe capture.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cycle_msb", {27'd0, q0, qv0, done0, busy0, lr0},
          {27'd0, m_q0, m_qv, m_done, m_busy, !m_busy});
      chk("cycle_lsb", {27'd0, q1, qv1, done1, busy1, lr1},
          {27'd0, m_q1, m_qv, m_done, m_busy, !m_busy});
      if (qv0) begin
        cap0.push_back(q0);
        st0.push_back(cyc);
      end
      if (qv1) cap1.push_back(q1);
    end
  end

  function automatic logic [31:0] pack(input logic b[$]);
    logic [31:0] v;
    v = '0;
    foreach (b[i]) v = {v[30:0], b[i]};
    return v;
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_caps;
    cap0.delete();
    cap1.delete();
    st0.delete();
  endtask

  task automatic load(input logic [7:0] w);
    tick;
    d = w;
    load_valid = 1'b1;
    tick;
    load_valid = 1'b0;
  endtask

  // Advances until done0 is visible; counts cycles seen with load_ready low.
  task automatic run_until_done(output int nlow, output int ncyc);
    nlow = 0;
    ncyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (done0) begin
        ncyc = i;
        return;
      end
      if (!lr0) nlow++;
      tick;
    end
    chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 40; i++) begin
      if (cap0.size() >= n) return;
      tick;
    end
    chk("bits_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nlow;
    int ncyc;
    int last_st;

    rst_n = 1'b0; d = '0; load_valid = 1'b0; shift_en = 1'b0; clr = 1'b0;
    tick;
    chk("reset_outputs", {27'd0, q0, qv0, done0, busy0, lr0}, 32'b00001);
    chk("reset_outputs_lsb", {27'd0, q1, qv1, done1, busy1, lr1}, 32'b00001);
    rst_n = 1'b1;
    tick;

    // A5 with shift_en held high
    clear_caps;
    shift_en = 1'b1;
    load(8'hA5);
    run_until_done(nlow, ncyc);
    chk("a5_msb_bits", pack(cap0), 32'hA5);
    chk("a5_lsb_bits", pack(cap1), 32'hA5);
    chk("a5_done_on_8th", cap0.size(), 32'd8);
    chk("a5_ready_low_cycles", nlow, 32'd8);
    chk("a5_done_latency", ncyc, 32'd8);
    tick; tick;
    chk("a5_q_hold_msb", {31'd0, q0}, 32'd1);
    chk("a5_q_hold_lsb", {31'd0, q1}, 32'd1);

    // F0 with shift_en toggling
    clear_caps;
    shift_en = 1'b0;
    load(8'hF0);
    for (int i = 0; i < 40; i++) begin
      shift_en = (i % 2 == 0);
      tick;
      if (done0) break;
    end
    chk("f0_msb_bits", pack(cap0), 32'hF0);
    chk("f0_lsb_bits", pack(cap1), 32'h0F);
    chk("f0_strobe_count", st0.size(), 32'd8);
    if (st0.size() == 8) begin
      chk("f0_strobe_span", st0[7] - st0[0], 32'd14);
      chk("f0_strobe_gap", st0[1] - st0[0], 32'd2);
    end

    // Back-to-back words with load_valid held
    clear_caps;
    shift_en = 1'b1;
    tick;
    d = 8'h3C;
    load_valid = 1'b1;
    tick;
    d = 8'hC3;
    run_until_done(nlow, ncyc);
    tick;
    load_valid = 1'b0;
    chk("b2b_second_accepted", {31'd0, busy0}, 32'd1);
    run_until_done(nlow, ncyc);
    chk("b2b_msb_bits", pack(cap0), 32'h3CC3);
    chk("b2b_lsb_bits", pack(cap1), 32'h3CC3);
    if (st0.size() == 16) chk("b2b_gap", st0[8] - st0[7], 32'd2);
    else chk("b2b_strobe_count", st0.size(), 32'd16);

    // clr after three bits, with a load attempt in the same cycle
    tick;
    clear_caps;
    shift_en = 1'b1;
    load(8'hFF);
    wait_bits(3);
    clr = 1'b1;
    d = 8'h55;
    load_valid = 1'b1;
    tick;
    clr = 1'b0;
    load_valid = 1'b0;
    chk("clr_outputs", {27'd0, q0, qv0, done0, busy0, lr0}, 32'b00001);
    tick; tick;
    chk("clr_no_done", {31'd0, done0}, 32'd0);
    chk("clr_bits_sent", cap0.size(), 32'd3);
    clear_caps;
    load(8'h81);
    run_until_done(nlow, ncyc);
    chk("after_clr_msb_bits", pack(cap0), 32'h81);
    chk("after_clr_lsb_bits", pack(cap1), 32'h81);

    // Asynchronous reset during bit 5
    tick;
    clear_caps;
    load(8'hA5);
    wait_bits(4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {27'd0, q0, qv0, done0, busy0, lr0}, 32'b00001);
    chk("async_reset_lsb", {27'd0, q1, qv1, done1, busy1, lr1}, 32'b00001);
    tick;
    rst_n = 1'b1;
    clear_caps;
    shift_en = 1'b1;
    repeat (6) tick;
    chk("post_reset_no_strobe", cap0.size() + cap1.size(), 32'd0);
    last_st = st0.size();
    chk("post_reset_idle", {30'd0, busy0, lr0}, 32'b01);
    chk("post_reset_strobe_log", last_st, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
